mem_port_arbiter: RTL

- Shares the single memory port between the CPU instruction-fetch path and the load/store path.
- Each requester uses a req/ack handshake.
- Each transaction is registered and presented to memory with a valid/ready protocol, then completed back to the owning requester.
- Round-robin on simultaneous requests; a watchdog terminates transactions that memory never completes.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_watchdog.sv | 29 ++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM encoding,
// requester IDs and the round-robin pick rule.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 48;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic owner_t;

  localparam owner_t OWNER_I = 1'b0;
  localparam owner_t OWNER_D = 1'b1;

  // A lone requester always wins; on a tie the one not served last wins.
  function automatic owner_t rr_pick(input logic i_req, input logic d_req,
                                     input owner_t last_grant);
    if (i_req && d_req) begin
      return (last_grant == OWNER_D) ? OWNER_I : OWNER_D;
    end
    return d_req ? OWNER_D : OWNER_I;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Cycle counter bounding how long a memory request may wait for m_ready.
// expired is high once TIMEOUT-1 waiting cycles have been counted.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Saturates at LAST so the counter can never wrap even if left enabled.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and load/store paths,
// with round-robin arbitration and a watchdog on stalled memory requests.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                err,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wmask,
  input  logic                m_ready,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic [1:0]          dbg_state
);

  // Handshakes: a requester raises req with stable inputs and holds it until
  // its one-cycle ack. Memory sees m_req with constant m_* fields; a transfer
  // completes on any edge where m_req && m_ready, m_ready alone is ignored.

  state_t              state, state_nxt;
  owner_t              owner, last_grant, grant_owner;
  logic                grant, capture, cap_err;
  logic                wd_en, wd_expired;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    grant_owner = owner;
    capture     = 1'b0;
    cap_err     = 1'b0;
    wd_en       = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant       = 1'b1;
          grant_owner = rr_pick(i_req, d_req, last_grant);
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        if (m_ready) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else if (wd_expired) begin
          capture   = 1'b1;
          cap_err   = 1'b1;
          state_nxt = RESP;
        end else begin
          wd_en = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWNER_I;
      last_grant <= OWNER_D;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wmask    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner      <= grant_owner;
        last_grant <= grant_owner;
        if (grant_owner == OWNER_D) begin
          m_addr  <= d_addr;
          m_we    <= d_we;
          m_wdata <= d_wdata;
          m_wmask <= d_we ? d_wmask : '0;
        end else begin
          m_addr  <= i_addr;
          m_we    <= 1'b0;
          m_wdata <= '0;
          m_wmask <= '0;
        end
      end
      // Stores and timeouts return zero data so stale bus values never leak.
      if (capture) begin
        resp_err   <= cap_err;
        resp_rdata <= (cap_err || m_we) ? '0 : m_rdata;
      end
    end
  end

  assign m_req     = (state == BUSY);
  assign i_ack     = (state == RESP) && (owner == OWNER_I);
  assign d_ack     = (state == RESP) && (owner == OWNER_D);
  assign i_rdata   = i_ack ? resp_rdata : '0;
  assign d_rdata   = d_ack ? resp_rdata : '0;
  assign err       = (state == RESP) && resp_err;
  assign dbg_state = state;

endmodule
